comp_reg_arbiter: RTL

//   Shares the comparator pointer-register file among its three requesters: CSR pointer writes, fingerprint

---
 rtl/comp_reg_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/comp_reg_arbiter.sv
// Round-robin owner of the comparator pointer registers (csr / fprint / cmp), one op in flight; COMP_ARB_STATS_EN adds grant counters.
// Latency: req->strobe 1 cycle, rf ack->*_ack 1 cycle; level requests wait in IDLE until granted, watchdog abandons missing rf acks.
module comp_reg_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = 7,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_req,
    input  logic                 csr_op,
    output logic                 csr_ack,
    input  logic                 fprint_req,
    output logic                 fprint_ack,
    input  logic                 cmp_req,
    input  logic                 cmp_op,
    output logic                 cmp_ack,
    output logic                 reg_pointer_start_write,
    output logic                 reg_pointer_end_write,
    output logic                 reg_inc_head_pointer,
    output logic                 reg_inc_tail_pointer,
    output logic                 reg_reset_task,
    input  logic                 reg_pointer_ack,
    input  logic                 reg_inc_head_ack,
    input  logic                 reg_inc_tail_ack,
    input  logic                 reg_reset_task_ack,
    output logic [1:0]           grant_id,
    output logic                 timeout_err,
    input  logic                 err_clear,
    output logic [CNT_WIDTH-1:0] csr_grant_cnt,
    output logic [CNT_WIDTH-1:0] fprint_grant_cnt,
    output logic [CNT_WIDTH-1:0] cmp_grant_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

    localparam logic [1:0]          ID_NONE   = 2'd0;
    localparam logic [1:0]          ID_CSR    = 2'd1;
    localparam logic [1:0]          ID_FPRINT = 2'd2;
    localparam logic [1:0]          ID_CMP    = 2'd3;
    localparam logic [TO_WIDTH-1:0] TO_LIMIT  = TO_WIDTH'(TIMEOUT_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_winner;
    logic                  r_op;
    logic [1:0]            r_rr_ptr;
    logic [1:0]            r_hold;
    logic [TO_WIDTH-1:0]   r_wd;
    logic                  r_err;

    logic [2:0]            w_req_raw;
    logic [2:0]            w_hold_mask;
    logic [2:0]            w_req;
    logic [1:0]            w_pick;
    logic                  w_op_sel;
    logic                  w_match;
    logic [TO_WIDTH-1:0]   w_wd_inc;
    logic                  w_expire;

    assign w_req_raw = {cmp_req, fprint_req, csr_req};

    // r_hold is only non-zero during the IDLE cycle that follows DONE
    always_comb begin
        w_hold_mask = 3'b000;
        case (r_hold)
            ID_CSR:    w_hold_mask = 3'b001;
            ID_FPRINT: w_hold_mask = 3'b010;
            ID_CMP:    w_hold_mask = 3'b100;
            default:   w_hold_mask = 3'b000;
        endcase
        w_req  = w_req_raw & ~w_hold_mask;
        w_pick = ID_NONE;
        case (r_rr_ptr)
            ID_FPRINT: begin
                if (w_req[1])      w_pick = ID_FPRINT;
                else if (w_req[2]) w_pick = ID_CMP;
                else if (w_req[0]) w_pick = ID_CSR;
            end
            ID_CMP: begin
                if (w_req[2])      w_pick = ID_CMP;
                else if (w_req[0]) w_pick = ID_CSR;
                else if (w_req[1]) w_pick = ID_FPRINT;
            end
            default: begin
                if (w_req[0])      w_pick = ID_CSR;
                else if (w_req[1]) w_pick = ID_FPRINT;
                else if (w_req[2]) w_pick = ID_CMP;
            end
        endcase
    end

    assign w_op_sel = (w_pick == ID_CSR) ? csr_op :
                      (w_pick == ID_CMP) ? cmp_op : 1'b0;

    always_comb begin
        w_match = 1'b0;
        case (r_winner)
            ID_CSR:    w_match = reg_pointer_ack;
            ID_FPRINT: w_match = reg_inc_head_ack;
            ID_CMP:    w_match = r_op ? reg_reset_task_ack : reg_inc_tail_ack;
            default:   w_match = 1'b0;
        endcase
    end

    // A matching ack in the expiry cycle completes the op cleanly
    assign w_wd_inc = r_wd + TO_WIDTH'(1);
    assign w_expire = (r_state == ST_WAIT) && !w_match && (w_wd_inc == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt             = r_state;
        reg_pointer_start_write = 1'b0;
        reg_pointer_end_write   = 1'b0;
        reg_inc_head_pointer    = 1'b0;
        reg_inc_tail_pointer    = 1'b0;
        reg_reset_task          = 1'b0;
        csr_ack                 = 1'b0;
        fprint_ack              = 1'b0;
        cmp_ack                 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick != ID_NONE) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                case (r_winner)
                    ID_CSR: begin
                        reg_pointer_start_write = !r_op;
                        reg_pointer_end_write   = r_op;
                    end
                    ID_FPRINT: reg_inc_head_pointer = 1'b1;
                    ID_CMP: begin
                        reg_inc_tail_pointer = !r_op;
                        reg_reset_task       = r_op;
                    end
                    default: ;
                endcase
            end
            ST_WAIT: begin
                if (w_match || w_expire) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                csr_ack     = (r_winner == ID_CSR);
                fprint_ack  = (r_winner == ID_FPRINT);
                cmp_ack     = (r_winner == ID_CMP);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner <= ID_NONE;
            r_op     <= 1'b0;
            r_rr_ptr <= ID_CSR;
            r_hold   <= ID_NONE;
            r_wd     <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_expire)       r_err <= 1'b1;
            else if (err_clear) r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_hold <= ID_NONE;
                    if (w_pick != ID_NONE) begin
                        r_winner <= w_pick;
                        r_op     <= w_op_sel;
                    end
                end
                ST_ISSUE: r_wd <= '0;
                ST_WAIT:  r_wd <= w_wd_inc;
                ST_DONE: begin
                    r_rr_ptr <= (r_winner == ID_CMP) ? ID_CSR : r_winner + 2'd1;
                    r_hold   <= r_winner;
                end
                default: ;
            endcase
        end
    end

    assign grant_id    = (r_state == ST_IDLE) ? ID_NONE : r_winner;
    assign timeout_err = r_err;

`ifdef COMP_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] r_csr_cnt;
    logic [CNT_WIDTH-1:0] r_fprint_cnt;
    logic [CNT_WIDTH-1:0] r_cmp_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csr_cnt    <= '0;
            r_fprint_cnt <= '0;
            r_cmp_cnt    <= '0;
        end else if (r_state == ST_DONE) begin
            if (r_winner == ID_CSR && r_csr_cnt != '1)
                r_csr_cnt <= r_csr_cnt + CNT_WIDTH'(1);
            if (r_winner == ID_FPRINT && r_fprint_cnt != '1)
                r_fprint_cnt <= r_fprint_cnt + CNT_WIDTH'(1);
            if (r_winner == ID_CMP && r_cmp_cnt != '1)
                r_cmp_cnt <= r_cmp_cnt + CNT_WIDTH'(1);
        end
    end

    assign csr_grant_cnt    = r_csr_cnt;
    assign fprint_grant_cnt = r_fprint_cnt;
    assign cmp_grant_cnt    = r_cmp_cnt;
`else
    assign csr_grant_cnt    = '0;
    assign fprint_grant_cnt = '0;
    assign cmp_grant_cnt    = '0;
`endif

endmodule
